// File: rtl/sarray_spm_resp.sv
// Scratchpad responder for the sarray AR/R/AW channels over a single-port line array.
// Optional macro SPM_ADDR_CHECK_EN: flag and neutralise out-of-range line addresses.
module sarray_spm_resp #(
    parameter int ADDR_W     = 64,
    parameter int LOAD_W     = 2048,
    parameter int STORE_W    = 2048,
    parameter int DEPTH      = 1024,
    parameter int LINE_SHIFT = 8,
    parameter int RD_LAT     = 2,
    parameter int OSTD       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sarray_ar_valid_i,
    output logic              sarray_ar_ready_o,
    input  logic [ADDR_W-1:0] sarray_ar_addr_i,
    output logic              sarray_r_valid_o,
    input  logic              sarray_r_ready_i,
    output logic [LOAD_W-1:0] sarray_r_data_o,
    input  logic               sarray_aw_valid_i,
    output logic               sarray_aw_ready_o,
    input  logic [ADDR_W-1:0]  sarray_aw_addr_i,
    input  logic [STORE_W-1:0] sarray_aw_data_i,
    output logic               err_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = LINE_SHIFT + IDX_W;
    localparam int CW     = $clog2(OSTD + 1);
    localparam int PW     = (OSTD > 1) ? $clog2(OSTD) : 1;
    localparam int NS     = RD_LAT - 1;

    logic [STORE_W-1:0] r_mem [DEPTH];
    logic [LOAD_W-1:0]  r_fifo [OSTD];

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fcnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_prio_rd;

    logic [IDX_W-1:0]  w_ar_idx;
    logic [IDX_W-1:0]  w_aw_idx;
    logic              w_ar_oor;
    logic              w_aw_oor;
    logic              w_ar_elig;
    logic              w_ar_req;
    logic              w_conflict;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_r_hs;
    logic [LOAD_W-1:0] w_rd_data;
    logic              w_fifo_we;
    logic [LOAD_W-1:0] w_fifo_wd;
    logic              w_unused_lo;

    assign w_ar_idx = sarray_ar_addr_i[LINE_SHIFT +: IDX_W];
    assign w_aw_idx = sarray_aw_addr_i[LINE_SHIFT +: IDX_W];
    assign w_unused_lo = ^{sarray_ar_addr_i[LINE_SHIFT-1:0],
                           sarray_aw_addr_i[LINE_SHIFT-1:0]};

`ifdef SPM_ADDR_CHECK_EN
    logic r_err;

    assign w_ar_oor = |sarray_ar_addr_i[ADDR_W-1:HI_LSB];
    assign w_aw_oor = |sarray_aw_addr_i[ADDR_W-1:HI_LSB];
    assign err_o    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_ar_hs && w_ar_oor) || (w_aw_hs && w_aw_oor)) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_hi;

    // Upper bits are don't-care: lines alias across the address space.
    assign w_unused_hi = ^{sarray_ar_addr_i[ADDR_W-1:HI_LSB],
                           sarray_aw_addr_i[ADDR_W-1:HI_LSB]};
    assign w_ar_oor = 1'b0;
    assign w_aw_oor = 1'b0;
    assign err_o    = 1'b0;
`endif

    // Credit check uses the count before any same-cycle pop.
    assign w_ar_elig  = r_cnt < CW'(OSTD);
    assign w_ar_req   = sarray_ar_valid_i && w_ar_elig;
    assign w_conflict = w_ar_req && sarray_aw_valid_i;

    assign sarray_ar_ready_o = w_ar_elig && (!sarray_aw_valid_i || r_prio_rd);
    assign sarray_aw_ready_o = !w_ar_req || !r_prio_rd;

    assign w_ar_hs = sarray_ar_valid_i && sarray_ar_ready_o;
    assign w_aw_hs = sarray_aw_valid_i && sarray_aw_ready_o;
    assign w_r_hs  = sarray_r_valid_o && sarray_r_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_rd <= 1'b0;
        end else if (w_conflict) begin
            r_prio_rd <= !r_prio_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs && !w_aw_oor) begin
            r_mem[w_aw_idx] <= sarray_aw_data_i;
        end
    end

    assign w_rd_data = w_ar_oor ? '0 : r_mem[w_ar_idx];

    generate
        if (NS == 0) begin : g_nopipe
            assign w_fifo_we = w_ar_hs;
            assign w_fifo_wd = w_rd_data;
        end else begin : g_pipe
            logic [NS-1:0]     r_pv;
            logic [LOAD_W-1:0] r_pd [NS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_ar_hs;
                    for (int i = 1; i < NS; i++) begin
                        r_pv[i] <= r_pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_pd[0] <= w_rd_data;
                for (int i = 1; i < NS; i++) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end

            assign w_fifo_we = r_pv[NS-1];
            assign w_fifo_wd = r_pd[NS-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_fifo_we) begin
            r_fifo[r_wr_ptr] <= w_fifo_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_fcnt   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_cnt  <= r_cnt + CW'(w_ar_hs) - CW'(w_r_hs);
            r_fcnt <= r_fcnt + CW'(w_fifo_we) - CW'(w_r_hs);
            if (w_fifo_we) begin
                r_wr_ptr <= (r_wr_ptr == PW'(OSTD - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_r_hs) begin
                r_rd_ptr <= (r_rd_ptr == PW'(OSTD - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    assign sarray_r_valid_o = r_fcnt != '0;
    assign sarray_r_data_o  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_sarray_spm_resp.sv
// Directed bench for sarray_spm_resp: latency, ordering, credits, arbitration, reset.
// Define SPM_ADDR_CHECK_EN for both files to exercise the address check.
module tb_sarray_spm_resp;

    logic          clk;
    logic          rst_n;
    logic          ar_valid;
    logic          ar_ready;
    logic [63:0]   ar_addr;
    logic          r_valid;
    logic          r_ready;
    logic [2047:0] r_data;
    logic          aw_valid;
    logic          aw_ready;
    logic [63:0]   aw_addr;
    logic [2047:0] aw_data;
    logic          err;

    int checks;
    int failures;

    sarray_spm_resp dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sarray_ar_valid_i (ar_valid),
        .sarray_ar_ready_o (ar_ready),
        .sarray_ar_addr_i  (ar_addr),
        .sarray_r_valid_o  (r_valid),
        .sarray_r_ready_i  (r_ready),
        .sarray_r_data_o   (r_data),
        .sarray_aw_valid_i (aw_valid),
        .sarray_aw_ready_o (aw_ready),
        .sarray_aw_addr_i  (aw_addr),
        .sarray_aw_data_i  (aw_data),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2047:0] pat(input int n);
        logic [2047:0] v;
        for (int k = 0; k < 64; k++) begin
            v[k*32 +: 32] = (32'(n) * 32'h9E3779B1) ^ (32'(k) << 20) ^ 32'h5A5A0000;
        end
        return v;
    endfunction

    task automatic single_read(input logic [63:0] a,
                               output logic [2047:0] d, output bit ok);
        int n;
        ok = 1'b0;
        d = '0;
        ar_valid = 1'b1;
        ar_addr = a;
        r_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ar_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        if (n >= 10) return;
        n = 0;
        @(negedge clk);
        while (!r_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (r_valid) begin
            d = r_data;
            ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic single_write(input logic [63:0] a, input logic [2047:0] d);
        int n;
        aw_valid = 1'b1;
        aw_addr = a;
        aw_data = d;
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ar_valid = 1'b0;
        ar_addr = '0;
        r_ready = 1'b1;
        aw_valid = 1'b0;
        aw_addr = '0;
        aw_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_r_valid got=%b want=0", r_valid);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rst_err got=%b want=0", err);
        end
        checks++;
        if (ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ar_ready got=%b want=1", ar_ready);
        end
        checks++;
        if (aw_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_aw_ready got=%b want=1", aw_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        aw_valid = 1'b1;
        aw_addr = 64'h100;
        aw_data = pat(500);
        r_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (aw_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_aw_ready got=%b want=1", aw_ready);
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        ar_valid = 1'b1;
        ar_addr = 64'h100;
        @(negedge clk);
        checks++;
        if (ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ar_ready got=%b want=1", ar_ready);
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_early_valid got=%b want=0", r_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b1 || r_data !== pat(500)) begin
            failures++;
            $display("FAIL wr_data valid=%b got=%h want=%h",
                     r_valid, r_data[63:0], pat(500) >> 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_drain valid=%b ar_ready=%b want 0/1", r_valid, ar_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        int bad;
        int rx;
        logic [2047:0] exp_d;
        bit exp_v;
        bad = 0;
        for (int n = 0; n < 64; n++) begin
            aw_valid = 1'b1;
            aw_addr = 64'(n) << 8;
            aw_data = pat(n);
            @(negedge clk);
            if (!aw_ready) bad++;
            @(posedge clk); #1;
        end
        aw_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL burst_preload stalls=%0d want=0", bad);
        end
        bad = 0;
        rx = 0;
        r_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            ar_valid = (c < 64);
            ar_addr = 64'(c) << 8;
            @(negedge clk);
            if (c < 64 && !ar_ready) bad++;
            exp_v = (c >= 2 && c < 66);
            checks++;
            if (r_valid !== exp_v) begin
                failures++;
                $display("FAIL burst_valid cyc=%0d got=%b want=%b", c, r_valid, exp_v);
            end
            if (r_valid === 1'b1) begin
                exp_d = pat(rx);
                checks++;
                if (r_data !== exp_d) begin
                    failures++;
                    $display("FAIL burst_data beat=%0d got=%h want=%h",
                             rx, r_data[63:0], exp_d[63:0]);
                end
                rx++;
            end
            @(posedge clk); #1;
        end
        ar_valid = 1'b0;
        checks++;
        if (bad != 0 || rx != 64) begin
            failures++;
            $display("FAIL burst_count stalls=%0d beats=%0d want 0/64", bad, rx);
        end
    endtask

    task automatic test_backpressure();
        int s;
        int rxi;
        bit acc;
        bit pop;
        logic [2047:0] exp_d;
        s = 0;
        rxi = 0;
        r_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                ar_valid = (s < 6);
                ar_addr = 64'(10 + s) << 8;
                @(negedge clk);
                checks++;
                if (s != 4 || ar_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_credit accepted=%0d ar_ready=%b want 4/0", s, ar_ready);
                end
                exp_d = pat(10);
                checks++;
                if (r_valid !== 1'b1 || r_data !== exp_d) begin
                    failures++;
                    $display("FAIL bp_hold valid=%b got=%h want=%h",
                             r_valid, r_data[63:0], exp_d[63:0]);
                end
                @(posedge clk); #1;
                r_ready = 1'b1;
            end
            if (rxi == 6) break;
            ar_valid = (s < 6);
            ar_addr = 64'(10 + s) << 8;
            @(negedge clk);
            acc = ar_valid && ar_ready;
            pop = r_valid && r_ready;
            if (pop) begin
                exp_d = pat(10 + rxi);
                checks++;
                if (r_data !== exp_d) begin
                    failures++;
                    $display("FAIL bp_data beat=%0d got=%h want=%h",
                             rxi, r_data[63:0], exp_d[63:0]);
                end
            end
            @(posedge clk); #1;
            if (acc) s++;
            if (pop) rxi++;
        end
        ar_valid = 1'b0;
        checks++;
        if (s != 6 || rxi != 6) begin
            failures++;
            $display("FAIL bp_complete accepted=%0d beats=%0d want 6/6", s, rxi);
        end
    endtask

    task automatic test_conflict();
        logic [3:0] gw;
        int wi;
        int ri;
        int rx;
        bit aw_hs;
        bit ar_hs;
        logic [2047:0] exp_d;
        gw = 4'b0101;
        wi = 0;
        ri = 0;
        rx = 0;
        r_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            aw_valid = (c < 4);
            ar_valid = (c < 4);
            aw_addr = 64'(20 + wi) << 8;
            aw_data = pat(100 + wi);
            ar_addr = 64'(20 + ri) << 8;
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (aw_ready !== gw[c] || ar_ready !== !gw[c]) begin
                    failures++;
                    $display("FAIL cf_grant cyc=%0d aw_ready=%b ar_ready=%b want %b/%b",
                             c, aw_ready, ar_ready, gw[c], !gw[c]);
                end
            end
            aw_hs = aw_valid && aw_ready;
            ar_hs = ar_valid && ar_ready;
            if (r_valid === 1'b1) begin
                exp_d = pat(100 + rx);
                checks++;
                if (r_data !== exp_d) begin
                    failures++;
                    $display("FAIL cf_data beat=%0d got=%h want=%h",
                             rx, r_data[63:0], exp_d[63:0]);
                end
                rx++;
            end
            @(posedge clk); #1;
            if (aw_hs) wi++;
            if (ar_hs) ri++;
        end
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        checks++;
        if (rx != 2 || wi != 2 || ri != 2) begin
            failures++;
            $display("FAIL cf_count beats=%0d w=%0d r=%0d want 2/2/2", rx, wi, ri);
        end
    endtask

    task automatic test_read_before_write();
        logic [2047:0] d;
        logic [2047:0] exp_d;
        bit ok;
        r_ready = 1'b1;
        ar_valid = 1'b1;
        ar_addr = 64'(30) << 8;
        @(negedge clk);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        aw_valid = 1'b1;
        aw_addr = 64'(30) << 8;
        aw_data = pat(200);
        @(negedge clk);
        checks++;
        if (aw_ready !== 1'b1) begin
            failures++;
            $display("FAIL rbw_aw_ready got=%b want=1", aw_ready);
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        @(negedge clk);
        exp_d = pat(30);
        checks++;
        if (r_valid !== 1'b1 || r_data !== exp_d) begin
            failures++;
            $display("FAIL rbw_old valid=%b got=%h want=%h",
                     r_valid, r_data[63:0], exp_d[63:0]);
        end
        @(posedge clk); #1;
        single_read(64'(30) << 8, d, ok);
        exp_d = pat(200);
        checks++;
        if (!ok || d !== exp_d) begin
            failures++;
            $display("FAIL rbw_new ok=%b got=%h want=%h", ok, d[63:0], exp_d[63:0]);
        end
    endtask

    task automatic test_reset_midop();
        int stale;
        logic [2047:0] d;
        logic [2047:0] exp_d;
        bit ok;
        r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ar_valid = 1'b1;
            ar_addr = 64'(i) << 8;
            @(negedge clk);
            @(posedge clk); #1;
        end
        ar_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_inflight got=%b want=1", r_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_reset valid=%b ar_ready=%b want 0/1", r_valid, ar_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        r_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (r_valid !== 1'b0) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rm_stale beats=%0d want=0", stale);
        end
        single_read(64'(5) << 8, d, ok);
        exp_d = pat(5);
        checks++;
        if (!ok || d !== exp_d) begin
            failures++;
            $display("FAIL rm_after ok=%b got=%h want=%h", ok, d[63:0], exp_d[63:0]);
        end
    endtask

    task automatic test_addr_check();
        logic [2047:0] d;
        logic [2047:0] exp_d;
        logic exp_err;
        bit ok;
`ifdef SPM_ADDR_CHECK_EN
        exp_d = '0;
        exp_err = 1'b1;
`else
        exp_d = pat(0);
        exp_err = 1'b0;
`endif
        single_read(64'h40000, d, ok);
        checks++;
        if (!ok || d !== exp_d) begin
            failures++;
            $display("FAIL ac_oor_read ok=%b got=%h want=%h", ok, d[63:0], exp_d[63:0]);
        end
        @(negedge clk);
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL ac_err got=%b want=%b", err, exp_err);
        end
        @(posedge clk); #1;
        single_write(64'h40100, pat(300));
`ifdef SPM_ADDR_CHECK_EN
        exp_d = pat(1);
`else
        exp_d = pat(300);
`endif
        single_read(64'h100, d, ok);
        checks++;
        if (!ok || d !== exp_d) begin
            failures++;
            $display("FAIL ac_oor_write ok=%b got=%h want=%h", ok, d[63:0], exp_d[63:0]);
        end
        single_read(64'(7) << 8, d, ok);
        exp_d = pat(7);
        checks++;
        if (!ok || d !== exp_d) begin
            failures++;
            $display("FAIL ac_inrange ok=%b got=%h want=%h", ok, d[63:0], exp_d[63:0]);
        end
        @(negedge clk);
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL ac_err_sticky got=%b want=%b", err, exp_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_burst();
        test_backpressure();
        test_conflict();
        test_read_before_write();
        test_reset_midop();
        test_addr_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
